// File: rtl/cf_math_pkg.sv
// Purpose: small math helpers shared across the codebase.
// Contents: idx_width(n) -- bits needed to index n items (at least 1).
package cf_math_pkg;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/mempool_pkg.sv
// Purpose: cluster-level shared types.
// Contents: rob_entry_t -- one reorder-buffer slot (pending, done, error, data).
package mempool_pkg;

  typedef struct packed {
    logic        pending;
    logic        done;
    logic        error;
    logic [31:0] data;
  } rob_entry_t;

endpackage

// File: rtl/snitch_pkg.sv
// Purpose: data-port request/response bundles of the core.
// Contents: dreq_t (addr, write, amo, data, strb) and dresp_t (data, error).
package snitch_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
    logic [31:0] data;
    logic [3:0]  strb;
  } dreq_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } dresp_t;

endpackage

// File: rtl/core_rob_if.sv
// Purpose: shim-side request/response bus of core_rob, for benches and
//   wrappers that want to carry the data_q*/data_p* signals as one bundle.
// Modports: master = ROB side (drives requests, consumes responses),
//   slave = memory/shim side.
// Handshake: a beat transfers on every rising clock edge where valid and
//   ready are both high; valid must not wait on ready, and payload is only
//   meaningful while valid is high.
interface core_rob_if
  import cf_math_pkg::*;
#(
  parameter int unsigned DataWidth           = 32,
  parameter int unsigned AddrWidth           = 32,
  parameter int unsigned MaxOutStandingTrans = 8
);
  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned MetaIdWidth = idx_width(MaxOutStandingTrans);

  logic [AddrWidth-1:0]   qaddr;
  logic                   qwrite;
  logic [3:0]             qamo;
  logic [DataWidth-1:0]   qdata;
  logic [StrbWidth-1:0]   qstrb;
  logic [MetaIdWidth-1:0] qid;
  logic                   qvalid;
  logic                   qready;

  logic [DataWidth-1:0]   pdata;
  logic                   perror;
  logic [MetaIdWidth-1:0] pid;
  logic                   pvalid;
  logic                   pready;

  modport master (
    output qaddr, qwrite, qamo, qdata, qstrb, qid, qvalid, pready,
    input  qready, pdata, perror, pid, pvalid
  );

  modport slave (
    input  qaddr, qwrite, qamo, qdata, qstrb, qid, qvalid, pready,
    output qready, pdata, perror, pid, pvalid
  );
endinterface

// File: rtl/core_rob.sv
// Purpose: reorder buffer between a core data port and an out-of-order
//   memory shim. Requests pass straight through tagged with a slot id; the
//   shim may answer in any order, and responses are released to the core
//   strictly in issue order, one cycle after they land at the earliest.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   core_q*_i / core_qready_o   core request channel
//   core_p*_o / core_pready_i   core response channel (in order)
//   data_q*_o / data_qready_i   shim request channel, data_qid_o = slot id
//   data_p*_i / data_pready_o   shim response channel, data_pid_i = slot id
// Entry data width comes from mempool_pkg::rob_entry_t, so DataWidth and
//   AddrWidth are expected to stay at the core's native 32 bits.
module core_rob
  import cf_math_pkg::*;
  import snitch_pkg::*;
  import mempool_pkg::*;
#(
  parameter int unsigned DataWidth           = 32,
  parameter int unsigned AddrWidth           = 32,
  parameter int unsigned MaxOutStandingTrans = 8,
  localparam int unsigned StrbWidth          = DataWidth / 8,
  localparam int unsigned MetaIdWidth        = idx_width(MaxOutStandingTrans)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   core_qaddr_i,
  input  logic                   core_qwrite_i,
  input  logic [3:0]             core_qamo_i,
  input  logic [DataWidth-1:0]   core_qdata_i,
  input  logic [StrbWidth-1:0]   core_qstrb_i,
  input  logic                   core_qvalid_i,
  output logic                   core_qready_o,
  output logic [DataWidth-1:0]   core_pdata_o,
  output logic                   core_perror_o,
  output logic                   core_pvalid_o,
  input  logic                   core_pready_i,
  output logic [AddrWidth-1:0]   data_qaddr_o,
  output logic                   data_qwrite_o,
  output logic [3:0]             data_qamo_o,
  output logic [DataWidth-1:0]   data_qdata_o,
  output logic [StrbWidth-1:0]   data_qstrb_o,
  output logic [MetaIdWidth-1:0] data_qid_o,
  output logic                   data_qvalid_o,
  input  logic                   data_qready_i,
  input  logic [DataWidth-1:0]   data_pdata_i,
  input  logic                   data_perror_i,
  input  logic [MetaIdWidth-1:0] data_pid_i,
  input  logic                   data_pvalid_i,
  output logic                   data_pready_o
);
  localparam int unsigned CountWidth = MetaIdWidth + 1;

  logic [MetaIdWidth-1:0]         head_q, tail_q;
  logic [CountWidth-1:0]          count_q;
  logic [MaxOutStandingTrans-1:0] pending_q, done_q;
  logic [DataWidth-1:0]           data_q  [MaxOutStandingTrans];
  logic                           error_q [MaxOutStandingTrans];

  dreq_t      core_req;
  dresp_t     shim_resp;
  rob_entry_t head_entry;
  logic       full, empty, alloc, retire;

  // Request path: pure wires, tagged with the slot about to be allocated.
  assign core_req.addr  = core_qaddr_i;
  assign core_req.write = core_qwrite_i;
  assign core_req.amo   = core_qamo_i;
  assign core_req.data  = core_qdata_i;
  assign core_req.strb  = core_qstrb_i;

  assign data_qaddr_o  = core_req.addr;
  assign data_qwrite_o = core_req.write;
  assign data_qamo_o   = core_req.amo;
  assign data_qdata_o  = core_req.data;
  assign data_qstrb_o  = core_req.strb;
  assign data_qid_o    = tail_q;

  // full looks only at the registered count: a retirement this cycle does
  // not open the request path until the next one.
  assign full  = (count_q == CountWidth'(MaxOutStandingTrans));
  assign empty = (count_q == '0);

  assign data_qvalid_o = core_qvalid_i & ~full & ~rst_i;
  assign core_qready_o = data_qready_i & ~full;
  assign alloc         = data_qvalid_o & data_qready_i;

  // Every id handed out owns a slot, so responses can always be absorbed.
  assign data_pready_o = 1'b1;

  assign shim_resp.data  = data_pdata_i;
  assign shim_resp.error = data_perror_i;

  // Head view read only from registered storage: no response bypass.
  assign head_entry.pending = pending_q[head_q];
  assign head_entry.done    = done_q[head_q];
  assign head_entry.error   = error_q[head_q];
  assign head_entry.data    = data_q[head_q];

  assign core_pvalid_o = head_entry.pending & head_entry.done;
  assign core_pdata_o  = head_entry.data;
  assign core_perror_o = head_entry.error;
  assign retire        = core_pvalid_o & core_pready_i;

  // Control state. Allocation and retirement never hit the same slot: that
  // would need head == tail with the buffer both full and non-full.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      done_q    <= '0;
    end else begin
      if (retire) begin
        pending_q[head_q] <= 1'b0;
        done_q[head_q]    <= 1'b0;
        head_q            <= head_q + MetaIdWidth'(1);
      end
      if (data_pvalid_i) begin
        done_q[data_pid_i] <= 1'b1;
      end
      if (alloc) begin
        pending_q[tail_q] <= 1'b1;
        done_q[tail_q]    <= 1'b0;
        tail_q            <= tail_q + MetaIdWidth'(1);
      end
      if (alloc && !retire) begin
        count_q <= count_q + CountWidth'(1);
      end else if (retire && !alloc) begin
        count_q <= count_q - CountWidth'(1);
      end
    end
  end

  // Payload storage is deliberately left out of reset; pending/done gate it.
  always_ff @(posedge clk_i) begin
    if (data_pvalid_i) begin
      data_q[data_pid_i]  <= shim_resp.data;
      error_q[data_pid_i] <= shim_resp.error;
    end
  end

  resp_targets_waiting_slot: assert property (
    @(posedge clk_i) disable iff (rst_i)
    data_pvalid_i |-> (pending_q[data_pid_i] && !done_q[data_pid_i]))
    else $error("core_rob: response to id %0d that is not awaiting one", data_pid_i);

  release_needs_occupancy: assert property (
    @(posedge clk_i) disable iff (rst_i) core_pvalid_o |-> !empty)
    else $error("core_rob: response offered while occupancy is zero");

endmodule

// File: tb/tb_core_rob.sv
// Purpose: directed self-checking bench for core_rob: reset values, in-order
//   and reordered completion, full/wrap-around, simultaneous
//   allocate/respond/retire, core backpressure, reset mid-operation and
//   error propagation.
module tb_core_rob;
  import cf_math_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = idx_width(N);
  localparam int unsigned SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- core side ----------------
  logic [AW-1:0] core_qaddr;
  logic          core_qwrite;
  logic [3:0]    core_qamo;
  logic [DW-1:0] core_qdata;
  logic [SW-1:0] core_qstrb;
  logic          core_qvalid;
  logic          core_qready;
  logic [DW-1:0] core_pdata;
  logic          core_perror;
  logic          core_pvalid;
  logic          core_pready;

  core_rob_if #(.DataWidth(DW), .AddrWidth(AW), .MaxOutStandingTrans(N)) shim ();

  core_rob #(.DataWidth(DW), .AddrWidth(AW), .MaxOutStandingTrans(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_qaddr_i (core_qaddr),
    .core_qwrite_i(core_qwrite),
    .core_qamo_i  (core_qamo),
    .core_qdata_i (core_qdata),
    .core_qstrb_i (core_qstrb),
    .core_qvalid_i(core_qvalid),
    .core_qready_o(core_qready),
    .core_pdata_o (core_pdata),
    .core_perror_o(core_perror),
    .core_pvalid_o(core_pvalid),
    .core_pready_i(core_pready),
    .data_qaddr_o (shim.qaddr),
    .data_qwrite_o(shim.qwrite),
    .data_qamo_o  (shim.qamo),
    .data_qdata_o (shim.qdata),
    .data_qstrb_o (shim.qstrb),
    .data_qid_o   (shim.qid),
    .data_qvalid_o(shim.qvalid),
    .data_qready_i(shim.qready),
    .data_pdata_i (shim.pdata),
    .data_perror_i(shim.perror),
    .data_pid_i   (shim.pid),
    .data_pvalid_i(shim.pvalid),
    .data_pready_o(shim.pready)
  );

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All driving and sampling happens around the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  // Present one request, check pass-through and slot id, let it be accepted.
  task automatic issue(input int id);
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    exp_addr    = 32'h1000 + 32'(id) * 32'd4;
    exp_data    = 32'hD000_0000 | 32'(id);
    core_qaddr  = exp_addr;
    core_qdata  = exp_data;
    core_qwrite = id[0];
    core_qamo   = 4'(id);
    core_qstrb  = 4'hF;
    core_qvalid = 1'b1;
    #1;
    chk("issue_qid",    64'(shim.qid),    64'(id));
    chk("issue_qvalid", 64'(shim.qvalid), 64'd1);
    chk("issue_qaddr",  64'(shim.qaddr),  64'(exp_addr));
    chk("issue_qdata",  64'(shim.qdata),  64'(exp_data));
    chk("issue_qwrite", 64'(shim.qwrite), 64'(id % 2));
    chk("issue_qamo",   64'(shim.qamo),   64'(id % 16));
    cyc();
    core_qvalid = 1'b0;
  endtask

  task automatic respond_set(input int id, input logic [DW-1:0] d, input logic e);
    shim.pvalid = 1'b1;
    shim.pid    = IW'(id);
    shim.pdata  = d;
    shim.perror = e;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst          = 1'b1;
    core_qaddr   = '0;
    core_qwrite  = 1'b0;
    core_qamo    = '0;
    core_qdata   = '0;
    core_qstrb   = '0;
    core_qvalid  = 1'b1;
    core_pready  = 1'b0;
    shim.qready  = 1'b1;
    shim.pvalid  = 1'b0;
    shim.pid     = '0;
    shim.pdata   = '0;
    shim.perror  = 1'b0;

    // Reset behaviour
    cyc();
    chk("rst_pvalid",   64'(core_pvalid), 64'd0);
    chk("rst_qvalid",   64'(shim.qvalid), 64'd0);
    chk("rst_qready",   64'(core_qready), 64'd1);
    shim.qready = 1'b0;
    #1;
    chk("rst_qready_follows", 64'(core_qready), 64'd0);
    shim.qready = 1'b1;
    core_qvalid = 1'b0;
    chk("pready_tied", 64'(shim.pready), 64'd1);
    rst = 1'b0;
    cyc();
    chk("rst_count", 64'(dut.count_q), 64'd0);
    chk("rst_qid",   64'(shim.qid),    64'd0);

    // In order: ids 0,1,2 answered 0xA,0xB,0xC
    issue(0); issue(1); issue(2);
    chk("ino_count", 64'(dut.count_q), 64'd3);
    core_pready = 1'b1;
    respond_set(0, 32'hA, 1'b0);
    #1;
    chk("ino_no_bypass", 64'(core_pvalid), 64'd0);
    cyc();
    chk("ino_v0", 64'(core_pvalid), 64'd1);
    chk("ino_d0", 64'(core_pdata),  64'hA);
    respond_set(1, 32'hB, 1'b0);
    cyc();
    chk("ino_v1", 64'(core_pvalid), 64'd1);
    chk("ino_d1", 64'(core_pdata),  64'hB);
    respond_set(2, 32'hC, 1'b0);
    cyc();
    chk("ino_v2", 64'(core_pvalid), 64'd1);
    chk("ino_d2", 64'(core_pdata),  64'hC);
    shim.pvalid = 1'b0;
    cyc();
    chk("ino_drained", 64'(core_pvalid),   64'd0);
    chk("ino_count0",  64'(dut.count_q),   64'd0);

    // Reorder: ids 3,4,5 answered 5,3,4
    issue(3); issue(4); issue(5);
    respond_set(5, 32'h22, 1'b0);
    cyc();
    shim.pvalid = 1'b0;
    #1;
    chk("ro_wait_head", 64'(core_pvalid), 64'd0);
    respond_set(3, 32'h20, 1'b0);
    #1;
    chk("ro_no_bypass", 64'(core_pvalid), 64'd0);
    cyc();
    chk("ro_v3", 64'(core_pvalid), 64'd1);
    chk("ro_d3", 64'(core_pdata),  64'h20);
    respond_set(4, 32'h21, 1'b0);
    cyc();
    chk("ro_d4", 64'(core_pdata),  64'h21);
    shim.pvalid = 1'b0;
    cyc();
    chk("ro_v5", 64'(core_pvalid), 64'd1);
    chk("ro_d5", 64'(core_pdata),  64'h22);
    cyc();
    chk("ro_drained", 64'(core_pvalid), 64'd0);
    chk("ro_count0",  64'(dut.count_q), 64'd0);

    // Reset mid-operation with 4 outstanding (ids 6,7,0,1)
    core_pready = 1'b0;
    issue(6); issue(7); issue(0); issue(1);
    chk("rm_count4", 64'(dut.count_q), 64'd4);
    respond_set(6, 32'h55, 1'b0);
    cyc();
    shim.pvalid = 1'b0;
    #1;
    chk("rm_pre_pvalid", 64'(core_pvalid), 64'd1);
    rst         = 1'b1;
    core_qvalid = 1'b1;
    #1;
    chk("rm_pvalid",  64'(core_pvalid),   64'd0);
    chk("rm_count",   64'(dut.count_q),   64'd0);
    chk("rm_qvalid",  64'(shim.qvalid),   64'd0);
    chk("rm_qready",  64'(core_qready),   64'd1);
    cyc();
    rst         = 1'b0;
    core_qvalid = 1'b0;
    #1;
    chk("rm_next_qid", 64'(shim.qid),    64'd0);
    chk("rm_post_pv",  64'(core_pvalid), 64'd0);

    // Full: 8 outstanding, 9th blocked until one retires, then gets id 0
    for (int i = 0; i < 8; i++) issue(i);
    chk("full_count8", 64'(dut.count_q), 64'd8);
    core_qvalid = 1'b1;
    #1;
    chk("full_qready", 64'(core_qready), 64'd0);
    chk("full_qvalid", 64'(shim.qvalid), 64'd0);
    cyc();
    chk("full_hold8", 64'(dut.count_q), 64'd8);
    respond_set(0, 32'h30, 1'b0);
    cyc();
    shim.pvalid = 1'b0;
    core_pready = 1'b1;
    #1;
    chk("full_pv",          64'(core_pvalid), 64'd1);
    chk("full_pd",          64'(core_pdata),  64'h30);
    chk("full_no_comb_rdy", 64'(core_qready), 64'd0);
    cyc();
    core_pready = 1'b0;
    #1;
    chk("full_count7", 64'(dut.count_q), 64'd7);
    chk("full_qready1", 64'(core_qready), 64'd1);
    chk("full_wrap_id", 64'(shim.qid),    64'd0);
    cyc();
    core_qvalid = 1'b0;
    #1;
    chk("full_refill", 64'(dut.count_q), 64'd8);

    // Simultaneous: allocate id 3, respond id 1, retire id 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    issue(0); issue(1); issue(2);
    respond_set(0, 32'h40, 1'b0);
    cyc();
    respond_set(1, 32'h41, 1'b0);
    core_qvalid = 1'b1;
    core_pready = 1'b1;
    #1;
    chk("sim_qid", 64'(shim.qid),     64'd3);
    chk("sim_pv",  64'(core_pvalid),  64'd1);
    chk("sim_pd",  64'(core_pdata),   64'h40);
    cyc();
    core_qvalid = 1'b0;
    shim.pvalid = 1'b0;
    core_pready = 1'b0;
    #1;
    chk("sim_count", 64'(dut.count_q), 64'd3);
    chk("sim_pv1",   64'(core_pvalid), 64'd1);
    chk("sim_pd1",   64'(core_pdata),  64'h41);
    chk("sim_qid4",  64'(shim.qid),    64'd4);

    // Backpressure: head held 5 cycles while ids 2 (error) and 3 complete
    for (int k = 0; k < 5; k++) begin
      if (k == 0) respond_set(2, 32'h42, 1'b1);
      else if (k == 1) respond_set(3, 32'h43, 1'b0);
      else shim.pvalid = 1'b0;
      #1;
      chk("bp_pv",  64'(core_pvalid), 64'd1);
      chk("bp_pd",  64'(core_pdata),  64'h41);
      chk("bp_err", 64'(core_perror), 64'd0);
      cyc();
    end
    shim.pvalid = 1'b0;
    chk("bp_count", 64'(dut.count_q), 64'd3);
    core_pready = 1'b1;
    #1;
    chk("bp_d1", 64'(core_pdata), 64'h41);
    cyc();
    chk("bp_d2",  64'(core_pdata),  64'h42);
    chk("bp_e2",  64'(core_perror), 64'd1);
    cyc();
    chk("bp_d3",  64'(core_pdata),  64'h43);
    chk("bp_e3",  64'(core_perror), 64'd0);
    cyc();
    chk("bp_drained", 64'(core_pvalid), 64'd0);
    chk("bp_count0",  64'(dut.count_q), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_rob.md
CORE_ROB -- requirements
Module: core_rob

Interface
REQ-001 SHALL have parameter DataWidth, default 32: request/response data width.
REQ-002 SHALL have parameter AddrWidth, default 32: request address width.
REQ-003 SHALL have parameter MaxOutStandingTrans, default 8: number of reorder entries; power of two, at least 2.
REQ-004 SHALL derive localparams StrbWidth = DataWidth/8 and MetaIdWidth = idx_width(MaxOutStandingTrans).
REQ-005 SHALL have ports clk_i (in, 1, clock) and rst_i (in, 1, reset); reset is asynchronous and active-high.
REQ-006 SHALL have core request ports: core_qaddr_i (in, AddrWidth), core_qwrite_i (in, 1), core_qamo_i (in, 4), core_qdata_i (in, DataWidth), core_qstrb_i (in, StrbWidth), core_qvalid_i (in, 1) and core_qready_o (out, 1).
REQ-007 SHALL have core response ports: core_pdata_o (out, DataWidth), core_perror_o (out, 1), core_pvalid_o (out, 1) and core_pready_i (in, 1).
REQ-008 SHALL have shim request ports: data_qaddr_o, data_qwrite_o, data_qamo_o, data_qdata_o and data_qstrb_o (out, same widths as the core request fields); data_qid_o (out, MetaIdWidth); data_qvalid_o (out, 1); and data_qready_i (in, 1).
REQ-009 SHALL have shim response ports: data_pdata_i (in, DataWidth), data_perror_i (in, 1), data_pid_i (in, MetaIdWidth), data_pvalid_i (in, 1) and data_pready_o (out, 1).

Function
REQ-010 SHALL forward all core request fields to the shim request ports combinationally, with zero latency.
REQ-011 SHALL drive data_qvalid_o = core_qvalid_i & ~full and core_qready_o = data_qready_i & ~full.
REQ-012 SHALL drive data_qid_o = the tail pointer (tail).
REQ-013 SHALL, on an accepted shim request (data_qvalid_o & data_qready_i), mark entry[tail] as pending, clear its done bit, and increment tail modulo MaxOutStandingTrans.
REQ-014 SHALL tie data_pready_o to 1, because a slot is always reserved for every outstanding response.
REQ-015 SHALL, on data_pvalid_i, write data_pdata_i and data_perror_i into entry[data_pid_i] and set its done bit.
REQ-016 SHALL drive core_pvalid_o = entry[head].pending & entry[head].done, with core_pdata_o and core_perror_o taken from entry[head].
REQ-017 SHALL, on a core response handshake, clear entry[head] and increment head modulo MaxOutStandingTrans.
REQ-018 SHALL return responses to the core strictly in issue order, whatever order the shim returns them in.
REQ-019 SHALL impose a minimum of one cycle between a shim response arriving and its release to the core, with no bypass path.
REQ-020 SHALL keep an occupancy counter of MetaIdWidth+1 bits: increment on allocation only, decrement on retirement only, unchanged when both occur in the same cycle; full = (count == MaxOutStandingTrans), empty = (count == 0).
REQ-021 SHALL accept a new allocation in the same cycle the ROB is full and head retires only if count < MaxOutStandingTrans; full is evaluated on the registered count, so there is no combinational ready-from-retire path.
REQ-022 SHALL allow a shim response and a core retirement to target different entries in the same cycle with both taking effect.
REQ-023 SHALL allow a shim response to entry[head] in the cycle head is stalled; the response sets done and head releases on the next cycle.
REQ-024 SHALL raise an assertion failure if a shim response targets an entry that is not pending, or one whose done bit is already set.
REQ-025 SHALL hold core_pdata_o and core_perror_o stable while core_pvalid_o is high and core_pready_i is low.

Reset
REQ-026 SHALL, on rst_i, clear head, tail, count and all pending/done bits.
REQ-027 SHALL hold core_pvalid_o = 0 and data_qvalid_o = 0 during reset; core_qready_o follows data_qready_i, since full = 0.
REQ-028 SHALL discard all in-flight transactions on reset mid-operation, and shim responses arriving after reset SHALL trip the REQ-024 assertion.
REQ-029 SHALL reset only control state; entry data and error storage are not reset.

Structure
REQ-030 SHALL place the rob_entry_t typedef (pending, done, error, data) in mempool_pkg, and SHALL import dreq_t and dresp_t from snitch_pkg for internal bundling.
REQ-031 SHALL use idx_width from cf_math_pkg.
REQ-032 SHALL consist of one flat module with no sub-module; entry storage is a flop array.

Verification
REQ-033 In-order: 3 loads with IDs 0,1,2 answered in order, data 0xA,0xB,0xC -> core receives 0xA,0xB,0xC, each one cycle after arrival.
REQ-034 Reorder: IDs 0,1,2 answered in order 2,0,1 -> core receives ID0 data, then ID1, then ID2; core_pvalid_o stays low until ID0 arrives.
REQ-035 Full: 8 requests issued with no responses -> core_qready_o = 0 on the 9th; after one retirement, the 9th is accepted with data_qid_o = 0 (wrap-around).
REQ-036 Backpressure: core_pready_i = 0 for 5 cycles with entries done -> core_pvalid_o held high with stable data; no loss or duplication.
REQ-037 Simultaneous: allocate ID 3, shim response to ID 1 and retire ID 0 in one cycle -> count unchanged, all three effects visible next cycle.
REQ-038 Reset mid-operation: 4 outstanding, rst_i pulsed -> count = 0, core_pvalid_o = 0, next data_qid_o = 0; error response (data_perror_i = 1) propagates to core_perror_o = 1.
